// File: rtl/dm_pkg.sv
// Shared memory-access encodings for the data memory and the controller that drives MemOp.
package dm_pkg;

    localparam logic [2:0] MEM_WORD  = 3'b000;
    localparam logic [2:0] MEM_HALF  = 3'b001;
    localparam logic [2:0] MEM_HALFU = 3'b010;
    localparam logic [2:0] MEM_BYTE  = 3'b011;
    localparam logic [2:0] MEM_BYTEU = 3'b100;

    localparam int unsigned DM_DEPTH = 3072;

    // Codes 101..111 perform no access.
    function automatic logic mem_op_none(input logic [2:0] op);
        return op > MEM_BYTEU;
    endfunction

endpackage

// File: rtl/dm_ext.sv
// Load-path lane select with sign or zero extension according to the access type.
module dm_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  mem_op,
    output logic [31:0] rd
);

    logic [31:0] shifted;
    logic [15:0] half_v;
    logic [7:0]  byte_v;

    assign shifted = word >> {lane, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        rd = '0;
        case (mem_op)
            MEM_WORD:  rd = word;
            MEM_HALF:  rd = {{16{half_v[15]}}, half_v};
            MEM_HALFU: rd = {16'h0000, half_v};
            MEM_BYTE:  rd = {{24{byte_v[7]}}, byte_v};
            MEM_BYTEU: rd = {24'h000000, byte_v};
            default:   rd = '0;
        endcase
    end

endmodule

// File: rtl/dm.sv
// Data memory: combinational loads, edge-committed stores with sub-word merge, and
// suppression of misaligned or out-of-range accesses.
module dm
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH = DM_DEPTH,
    parameter int unsigned AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [2:0]  MemOp,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        AddrErr
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          op_none;
    logic          misaligned;
    logic          out_of_range;
    logic [31:0]   mem_word;
    logic [31:0]   ext_rd;
    logic [31:0]   wdata;

    assign idx          = Addr[AW+1:2];
    assign op_none      = mem_op_none(MemOp);
    // Comparing the full word address also catches any nonzero bits above the index.
    assign out_of_range = {2'b00, Addr[31:2]} >= 32'(DEPTH);

    always_comb begin
        misaligned = 1'b0;
        case (MemOp)
            MEM_WORD:             misaligned = Addr[1:0] != 2'b00;
            MEM_HALF, MEM_HALFU:  misaligned = Addr[0];
            default:              misaligned = 1'b0;
        endcase
    end

    assign AddrErr  = !op_none && (misaligned || out_of_range);
    assign mem_word = out_of_range ? '0 : mem[idx];

    dm_ext u_ext (
        .word   (mem_word),
        .lane   (Addr[1:0]),
        .mem_op (MemOp),
        .rd     (ext_rd)
    );

    assign RD = (op_none || AddrErr) ? '0 : ext_rd;

    always_comb begin
        wdata = mem_word;
        case (MemOp)
            MEM_WORD:            wdata = WD;
            MEM_HALF, MEM_HALFU: wdata[{Addr[1], 4'b0000} +: 16] = WD[15:0];
            MEM_BYTE, MEM_BYTEU: wdata[{Addr[1:0], 3'b000} +: 8] = WD[7:0];
            default:             wdata = mem_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (WE && !op_none && !AddrErr) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_dm.sv
// Randomized and directed checks of the data memory against a byte-addressed reference model.
module tb_dm;
    import dm_pkg::*;

    localparam int DEPTH = 3072;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [2:0]  MemOp;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        AddrErr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_mem [NBYTES];

    dm #(.DEPTH(DEPTH), .AW(12)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .WE      (WE),
        .MemOp   (MemOp),
        .Addr    (Addr),
        .WD      (WD),
        .RD      (RD),
        .AddrErr (AddrErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (op=%0d addr=%08h)", tag, got, exp, MemOp,
                     Addr);
        end
    endtask

    function automatic bit model_err(input logic [2:0] op, input logic [31:0] a);
        if (op > 3'd4) return 1'b0;
        if (a >= 32'(NBYTES)) return 1'b1;
        if (op == 3'd0) return a % 4 != 0;
        if (op == 3'd1 || op == 3'd2) return a % 2 != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [2:0] op, input logic [31:0] a);
        int i;
        logic [7:0]  b;
        logic [15:0] h;
        if (op > 3'd4 || model_err(op, a)) return 32'h0;
        i = int'(a);
        b = ref_mem[i];
        h = {ref_mem[i+1], ref_mem[i]};
        case (op)
            3'd0:    return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return {16'h0, h};
            3'd3:    return {{24{b[7]}}, b};
            default: return {24'h0, b};
        endcase
    endfunction

    task automatic model_clock(input bit rst, input bit we_v, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] wd_v);
        int nb;
        if (rst) begin
            for (int k = 0; k < NBYTES; k++) ref_mem[k] = 8'h00;
        end else if (we_v && op <= 3'd4 && !model_err(op, a)) begin
            nb = (op == 3'd0) ? 4 : (op <= 3'd2) ? 2 : 1;
            for (int k = 0; k < nb; k++) ref_mem[int'(a) + k] = wd_v[8*k +: 8];
        end
    endtask

    // One cycle: apply inputs, compare outputs to the model, clock, update the model.
    task automatic drive(input bit rst, input bit we_v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] wd_v);
        reset = rst; WE = we_v; MemOp = op; Addr = a; WD = wd_v;
        #2;
        check("rd_model", RD, model_rd(op, a));
        check("err_model", {31'b0, AddrErr}, {31'b0, model_err(op, a)});
        @(posedge clk);
        model_clock(rst, we_v, op, a, wd_v);
        #1;
    endtask

    task automatic expect_read(input string tag, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] exp_rd, input bit exp_err);
        reset = 1'b0; WE = 1'b0; MemOp = op; Addr = a; WD = 32'h0;
        #2;
        check({tag, "_rd"}, RD, exp_rd);
        check({tag, "_err"}, {31'b0, AddrErr}, {31'b0, exp_err});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  op;
        reset = 1'b1; WE = 1'b0; MemOp = MEM_WORD; Addr = 32'h0; WD = 32'h0;
        @(posedge clk);
        model_clock(1'b1, 1'b0, MEM_WORD, 32'h0, 32'h0);
        #1;

        expect_read("rst0", MEM_WORD, 32'h0000_0000, 32'h0, 1'b0);
        expect_read("rst10", MEM_WORD, 32'h0000_0010, 32'h0, 1'b0);
        expect_read("rst2ffc", MEM_WORD, 32'h0000_2FFC, 32'h0, 1'b0);

        drive(1'b0, 1'b1, MEM_WORD, 32'h100, 32'h1234_5678);
        expect_read("w100", MEM_WORD, 32'h100, 32'h1234_5678, 1'b0);
        expect_read("b101", MEM_BYTEU, 32'h101, 32'h0000_0056, 1'b0);
        expect_read("b103s", MEM_BYTE, 32'h103, 32'h0000_0012, 1'b0);

        drive(1'b0, 1'b1, MEM_WORD, 32'h200, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, MEM_BYTE, 32'h202, 32'h0000_00A5);
        expect_read("w200", MEM_WORD, 32'h200, 32'hFFA5_FFFF, 1'b0);
        expect_read("b202s", MEM_BYTE, 32'h202, 32'hFFFF_FFA5, 1'b0);
        expect_read("b202u", MEM_BYTEU, 32'h202, 32'h0000_00A5, 1'b0);

        drive(1'b0, 1'b1, MEM_HALF, 32'h206, 32'h0000_8001);
        expect_read("h206s", MEM_HALF, 32'h206, 32'hFFFF_8001, 1'b0);
        expect_read("h206u", MEM_HALFU, 32'h206, 32'h0000_8001, 1'b0);
        drive(1'b0, 1'b1, MEM_HALF, 32'h205, 32'h0000_1234);
        expect_read("h205", MEM_HALF, 32'h205, 32'h0, 1'b1);
        expect_read("w204", MEM_WORD, 32'h204, 32'h8001_0000, 1'b0);

        drive(1'b0, 1'b1, MEM_WORD, 32'h3000, 32'hAAAA_AAAA);
        expect_read("w3000", MEM_WORD, 32'h3000, 32'h0, 1'b1);
        drive(1'b0, 1'b1, MEM_WORD, 32'h102, 32'hBBBB_BBBB);
        expect_read("w102", MEM_WORD, 32'h102, 32'h0, 1'b1);
        expect_read("w100b", MEM_WORD, 32'h100, 32'h1234_5678, 1'b0);
        expect_read("hi_bits", MEM_BYTEU, 32'h0001_0100, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 3'b111, 32'h0, 32'hCCCC_CCCC);
        expect_read("none", 3'b111, 32'h0, 32'h0, 1'b0);
        expect_read("w0", MEM_WORD, 32'h0, 32'h0, 1'b0);

        drive(1'b1, 1'b1, MEM_WORD, 32'h40, 32'hDEAD_BEEF);
        expect_read("rstwr40", MEM_WORD, 32'h40, 32'h0, 1'b0);
        expect_read("rst100", MEM_WORD, 32'h100, 32'h0, 1'b0);

        // Read-during-write on the same word: old contents now, new contents next cycle.
        drive(1'b0, 1'b1, MEM_WORD, 32'h300, 32'h1111_1111);
        reset = 1'b0; WE = 1'b1; MemOp = MEM_WORD; Addr = 32'h300; WD = 32'hCAFE_F00D;
        #2;
        check("rdw_old", RD, 32'h1111_1111);
        @(posedge clk);
        model_clock(1'b0, 1'b1, MEM_WORD, 32'h300, 32'hCAFE_F00D);
        #1;
        expect_read("rdw_new", MEM_WORD, 32'h300, 32'hCAFE_F00D, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 'h3F));
                1:       a = 32'($urandom_range('h2FF0, 'h300F));
                2:       a = 32'($urandom_range('h100, 'h11F));
                default: a = $urandom;
            endcase
            op = 3'($urandom_range(0, 7));
            drive($urandom_range(0, 99) == 0, 1'($urandom), op, a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm.md
Name: dm

Overview:
- Data memory stage directly downstream of the ALU. The ALU result C drives this block's Addr; the block performs word, halfword and byte loads and stores.
- Reads are combinational (zero latency). Writes commit on the rising clock edge.
- Misaligned and out-of-range accesses are detected and suppressed.
- Used in the single-cycle CPU datapath between the ALU and the GRF write-back mux.

Parameters:
- DEPTH, 3072: number of 32-bit words; byte address range is 0 .. 4*DEPTH-1 (default 0x0000..0x2FFF).
- AW, 12: word-index width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; clears every memory word to 0 on the rising edge.
- WE  input  1  store enable.
- MemOp  input  3  access type (encoding below).
- Addr  input  32  byte address, from ALU output C.
- WD  input  32  store data; the low byte/half is used for sub-word stores.
- RD  output  32  load data, extended per MemOp.
- AddrErr  output  1  combinational: access is misaligned or out of range.

Behaviour:
- MemOp encoding:
  - 000 WORD
  - 001 HALF signed
  - 010 HALF unsigned
  - 011 BYTE signed
  - 100 BYTE unsigned
  - 101-111 NONE
- Store width: WORD stores 32 bits; either HALF code stores 16 bits; either BYTE code stores 8 bits. Signedness is ignored on stores.
- Word index = Addr[AW+1:2]; byte lane = Addr[1:0]; half lane = Addr[1].
- Alignment rules:
  - WORD requires Addr[1:0]==00.
  - HALF requires Addr[0]==0.
  - BYTE is always aligned.
- Range rule: Addr >= 4*DEPTH is out of range, including any nonzero Addr[31:AW+2].
- AddrErr = (MemOp != NONE) & (misaligned | out of range). It is combinational and independent of WE.
- Read path (combinational):
  - RD = extended lane of mem[index].
  - Byte lane k = bits [8k+7:8k]; half lane h = bits [16h+15:16h].
  - Signed codes sign-extend; unsigned codes zero-extend.
  - RD = 0 when MemOp is NONE or AddrErr=1.
- Write path (rising edge):
  - Commits only when WE=1, MemOp != NONE and AddrErr=0.
  - A sub-word store modifies only the addressed lane; all other bytes of the word are preserved (read-modify-write within the same cycle).
- Read-during-write, same word: RD shows the old contents during the write cycle and the new contents in the following cycle. There is no bypass.
- Reset:
  - Synchronous; has priority over any write in the same cycle; all words read 0 afterwards.
  - Reset mid-operation discards the pending store.
  - RD reflects the cleared memory in the next cycle.
- After reset, RD = 0 and AddrErr is purely a function of its inputs.
- An erroneous store leaves memory unchanged; there is no sticky error state.

Decomposition:
- Shared package: MemOp localparams (MEM_WORD, MEM_HALF, MEM_HALFU, MEM_BYTE, MEM_BYTEU) and the DEPTH default. The same constants are reused by the controller.
- One sub-module, dm_ext: combinational lane select plus sign/zero extension (inputs: word, Addr[1:0], MemOp; output: RD).
- Store lane merging stays in dm.

Test Plan:
- Reset pulse, then WORD read at 0x0, 0x10 and 0x2FFC -> RD=0x00000000 and AddrErr=0 at each address.
- WORD store 0x12345678 @0x100; next cycle WORD read -> 0x12345678. BYTE read @0x101 -> 0x00000056; BYTE signed @0x103 -> 0x00000012.
- Preload 0xFFFFFFFF @0x200, then BYTE store WD=0x000000A5 @0x202 -> word 0xFFA5FFFF. BYTE signed @0x202 -> 0xFFFFFFA5; BYTE unsigned -> 0x000000A5.
- HALF store 0x8001 @0x206, then HALF signed read @0x206 -> 0xFFFF8001 and HALF unsigned -> 0x00008001. HALF store @0x205 -> AddrErr=1 and word unchanged.
- WORD store @0x3000 and @0x102 -> AddrErr=1, RD=0, no memory change. MemOp=111 with WE=1 @0x0 -> AddrErr=0, RD=0, no write.
- WE=1 WORD store 0xDEADBEEF @0x40 in the same cycle as reset=1 -> the next-cycle read @0x40 returns 0. Same-cycle read-during-write -> old value shown, new value visible the following cycle.
